motor_enable_seq: RTL and testbench
===================================

Name: motor_enable_seq

Overview:
Parametrised successor to the fixed six-motor enable register.
- Accepts indexed enable/disable commands over a valid/ready handshake and drives N_MOTORS enable lines.
- Disables take effect immediately.
- Enables pass through a soft-start sequencer: at most one channel turns on per ENABLE_DELAY window, in ascending index order, which limits inrush current.
- Sits between the command decoder and the motor driver enable pins.

Parameters:
N_MOTORS, 6, number of enable outputs (1..2**IDX_W).
IDX_W, 8, width of the motor index field.
ENABLE_DELAY, 1000, stagger cycles before each enable is applied (>=1).
WD_TIMEOUT, 1000000, watchdog period in cycles; used only with WATCHDOG_EN.

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_motor  in  IDX_W  target motor index
cmd_state  in  2  opcode: 00 disable, 01 enable, 10 disable-all, 11 enable-all
en  out  N_MOTORS  motor enable lines, bit i = motor i
busy  out  1  sequencer active or enables pending
cmd_err  out  1  one-cycle pulse on an out-of-range index
wd_trip  out  1  watchdog tripped, sticky

Behaviour:
- Interface: one clock, `clock`; reset is synchronous, active-low, on `reset_n`.
- Reset (reset_n=0 at an edge): en=0, pending=0, FSM=IDLE, counter=0, cmd_err=0, wd_trip=0, cmd_ready=0.
  - cmd_ready is registered and goes to 1 on the first edge with reset_n=1.
  - Reset mid-sequence aborts everything.
- Accept: a command is accepted on an edge where cmd_valid & cmd_ready. cmd_ready stays 1 outside reset.
- Disable (00), idx < N_MOTORS:
  - en[idx] goes to 0 at the acceptance edge, visible the next cycle.
  - pending[idx] is cleared.
  - If idx is the channel in DELAY/APPLY, the FSM returns to IDLE at that edge and en[idx] stays 0.
- Enable (01), idx < N_MOTORS:
  - pending[idx] is set unless en[idx] is already 1.
  - Re-enabling an already-pending channel is a no-op.
- Disable-all (10): en=0, pending=0, FSM=IDLE at the acceptance edge. cmd_motor is ignored.
- Enable-all (11): pending |= ~en over the valid channels.
- Out-of-range idx on 00/01: no state change; cmd_err=1 for exactly the next cycle.
- FSM:
  - IDLE: if pending!=0, cur <= lowest set index, cnt <= ENABLE_DELAY-1, go to DELAY.
  - DELAY: if cnt==0 go to APPLY, else cnt--.
  - APPLY: en[cur] <= 1, pending[cur] <= 0, go to IDLE.
- Latency: an enable accepted at edge t with an idle sequencer gives en[idx]=1 after edge t+ENABLE_DELAY+2. Consecutive queued channels are spaced ENABLE_DELAY+2 cycles apart.
- Simultaneous events: a command that arrives in the same cycle as an APPLY for the same channel takes precedence over the APPLY. Example: disable at the APPLY edge leaves en=0.
- busy = (FSM != IDLE) | (pending != 0).

Optional Feature:
Macro MOTOR_ENABLE_WATCHDOG_EN.
- Defined:
  - A counter is cleared on every accepted command and increments otherwise.
  - On reaching WD_TIMEOUT-1 it performs the disable-all action and sets wd_trip=1.
  - wd_trip clears on the next accepted command; that command still executes.
- Undefined: no counter; wd_trip tied to 0.

Decomposition:
- Package motor_en_pkg: opcode constants CMD_DIS/CMD_EN/CMD_DIS_ALL/CMD_EN_ALL and the FSM state enum {IDLE, DELAY, APPLY}.
- Sub-module motor_en_prio_pick: combinational lowest-set-bit picker over N_MOTORS, outputting index and a found flag.

Test Plan:
Bench parameters: N_MOTORS=6, ENABLE_DELAY=4, WD_TIMEOUT=50.
- Reset/enable latency: hold reset_n=0 then release; enable motor 2 at edge t -> en=000000 until en[2]=1 after edge t+6; busy high from t to t+6.
- Disable: with en=6'b000100, disable motor 2 -> en=0 the next cycle; no FSM activity.
- Enable-all stagger: with en=0, issue enable-all -> en bits 0..5 rise in order, 6 cycles apart; busy drops after the last.
- Cancel in DELAY: enable 3, then disable 3 two cycles later -> en[3] never rises; FSM returns to IDLE.
- Cancel queue: enable-all, then disable-all mid-sequence -> en=0, pending=0, busy=0 the next cycle.
- Out-of-range: enable motor 6, then motor 255 -> cmd_err pulses one cycle each; en unchanged. With MOTOR_ENABLE_WATCHDOG_EN: idle 50 cycles -> en=0, wd_trip=1; the next command clears wd_trip.

Source files
------------

// File: rtl/motor_en_pkg.sv
// Shared opcodes and sequencer state encodings for the motor enable sequencer.
package motor_en_pkg;

    localparam logic [1:0] CMD_DIS     = 2'b00;
    localparam logic [1:0] CMD_EN      = 2'b01;
    localparam logic [1:0] CMD_DIS_ALL = 2'b10;
    localparam logic [1:0] CMD_EN_ALL  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

endpackage

// File: rtl/motor_en_prio_pick.sv
// Combinational lowest-set-bit picker: index of the lowest requesting channel.
module motor_en_prio_pick #(
    parameter int unsigned N     = 6,
    parameter int unsigned SEL_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] idx_c,
    output logic             found_c
);

    always_comb begin
        idx_c   = '0;
        found_c = |req;
        // Scan downward so the lowest set bit wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/motor_enable_seq.sv
// Indexed motor enable register with immediate disables and staggered soft-start enables.
// Optional watchdog auto-disable is built when MOTOR_ENABLE_WATCHDOG_EN is defined.
module motor_enable_seq
    import motor_en_pkg::*;
#(
    parameter int unsigned N_MOTORS     = 6,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned ENABLE_DELAY = 1000,
    parameter int unsigned WD_TIMEOUT   = 1000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IDX_W-1:0]    cmd_motor,
    input  logic [1:0]          cmd_state,
    output logic [N_MOTORS-1:0] en,
    output logic                busy,
    output logic                cmd_err,
    output logic                wd_trip
);

    localparam int unsigned SEL_W = (N_MOTORS > 1) ? $clog2(N_MOTORS) : 1;
    localparam int unsigned CNT_W = (ENABLE_DELAY > 1) ? $clog2(ENABLE_DELAY) : 1;

    // Elaboration-time parameter sanity checks.
    if (ENABLE_DELAY < 1) begin : g_bad_delay
        $error("ENABLE_DELAY must be at least 1");
    end
    if (N_MOTORS < 1) begin : g_bad_n
        $error("N_MOTORS must be at least 1");
    end
    if (WD_TIMEOUT < 2) begin : g_bad_wd
        $error("WD_TIMEOUT must be at least 2");
    end

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    cur_q, cur_d;
    logic [N_MOTORS-1:0] pending_q, pending_d;
    logic [N_MOTORS-1:0] en_q, en_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cmd_err_q, cmd_err_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic                in_range;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    pick_idx;
    logic                pick_found;

    motor_en_prio_pick #(
        .N     (N_MOTORS),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (pending_q),
        .idx_c   (pick_idx),
        .found_c (pick_found)
    );

`ifdef MOTOR_ENABLE_WATCHDOG_EN
    localparam int unsigned WD_W = (WD_TIMEOUT > 2) ? $clog2(WD_TIMEOUT) : 1;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_trip_q, wd_trip_d;
`endif

    assign accept   = cmd_valid & cmd_ready_q;
    assign in_range = 32'(cmd_motor) < N_MOTORS;
    assign sel      = SEL_W'(cmd_motor);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        pending_d   = pending_q;
        en_d        = en_q;
        cmd_ready_d = 1'b1;
        cmd_err_d   = 1'b0;
`ifdef MOTOR_ENABLE_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        wd_trip_d   = wd_trip_q;
`endif

        // Soft-start sequencer.
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    cnt_d   = CNT_W'(ENABLE_DELAY - 1);
                    state_d = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_APPLY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_APPLY: begin
                en_d[cur_q]      = 1'b1;
                pending_d[cur_q] = 1'b0;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MOTOR_ENABLE_WATCHDOG_EN
        if (accept) begin
            wd_cnt_d  = '0;
            wd_trip_d = 1'b0;
        end else if (wd_cnt_q == WD_W'(WD_TIMEOUT - 1)) begin
            wd_cnt_d  = '0;
            wd_trip_d = 1'b1;
            en_d      = '0;
            pending_d = '0;
            state_d   = ST_IDLE;
        end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif

        // Commands are applied after the sequencer so they win on the same channel.
        if (accept) begin
            case (cmd_state)
                CMD_DIS: begin
                    if (in_range) begin
                        en_d[sel]      = 1'b0;
                        pending_d[sel] = 1'b0;
                        if ((state_d != ST_IDLE) && (cur_d == sel)) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_EN: begin
                    if (in_range) begin
                        if (!en_d[sel]) begin
                            pending_d[sel] = 1'b1;
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_DIS_ALL: begin
                    en_d      = '0;
                    pending_d = '0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    pending_d = pending_d | ~en_d;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE) | (|pending_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            pending_q   <= '0;
            en_q        <= '0;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            pending_q   <= pending_d;
            en_q        <= en_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MOTOR_ENABLE_WATCHDOG_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_trip_q <= wd_trip_d;
        end
    end

    assign wd_trip = wd_trip_q;
`else
    assign wd_trip = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;
    assign en        = en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_motor_enable_seq.sv
// Scoreboard bench for motor_enable_seq: expected en/cmd_err events are queued with
// their edge number and a negedge monitor pops and compares on every output change.
module tb_motor_enable_seq;

    localparam int unsigned N  = 6;
    localparam int unsigned IW = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned WD = 50;

    localparam logic [1:0] OP_DIS     = 2'b00;
    localparam logic [1:0] OP_EN      = 2'b01;
    localparam logic [1:0] OP_DIS_ALL = 2'b10;
    localparam logic [1:0] OP_EN_ALL  = 2'b11;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [IW-1:0] cmd_motor = '0;
    logic [1:0]    cmd_state = '0;
    logic          cmd_ready;
    logic [N-1:0]  en;
    logic          busy;
    logic          cmd_err;
    logic          wd_trip;

    typedef struct {
        int           cyc;
        logic [N-1:0] en;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;
    logic [N-1:0] prev_en;
    int           t;

    motor_enable_seq #(
        .N_MOTORS     (N),
        .IDX_W        (IW),
        .ENABLE_DELAY (D),
        .WD_TIMEOUT   (WD)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_motor (cmd_motor),
        .cmd_state (cmd_state),
        .en        (en),
        .busy      (busy),
        .cmd_err   (cmd_err),
        .wd_trip   (wd_trip)
    );

    always #5 clock = ~clock;

    // Edge counter: after rising edge k, cyc == k when sampled at the following negedge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [N-1:0] e, input logic r);
        exp_q.push_back('{cyc: c, en: e, err: r});
    endtask

    // Called at a negedge; command is accepted at the next rising edge (cyc+1).
    task automatic issue(input logic [1:0] op, input logic [IW-1:0] idx);
        cmd_state = op;
        cmd_motor = idx;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Monitor: any change on en or a cmd_err pulse is an output event.
    always @(negedge clock) begin
        if (mon_en) begin
            if ((en !== prev_en) || (cmd_err !== 1'b0)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got cyc %0d en %b err %b, expected no event",
                             cyc, en, cmd_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((mon_e.cyc != cyc) || (mon_e.en !== en) || (mon_e.err !== cmd_err)) begin
                        errors++;
                        $display("FAIL event: got cyc %0d en %b err %b, expected cyc %0d en %b err %b",
                                 cyc, en, cmd_err, mon_e.cyc, mon_e.en, mon_e.err);
                    end
                end
            end
            prev_en = en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_en", 32'(en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cmd_err", 32'(cmd_err), 32'h0);
        check("rst_wd_trip", 32'(wd_trip), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'h1);
        prev_en = en;
        mon_en  = 1'b1;

        // Enable motor 2: en[2] rises after edge t+6, busy high for edges t..t+5
        t = cyc + 1;
        push(t + 6, 6'b000100, 1'b0);
        issue(OP_EN, 8'd2);
        for (int k = 0; k < 6; k++) begin
            check("busy_during_enable", 32'(busy), 32'h1);
            @(negedge clock);
        end
        check("busy_after_enable", 32'(busy), 32'h0);

        // Immediate disable, no sequencer activity
        t = cyc + 1;
        push(t, 6'b000000, 1'b0);
        issue(OP_DIS, 8'd2);
        check("busy_after_disable", 32'(busy), 32'h0);

        // Enable-all stagger: bits rise in order every D+2 cycles
        t = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            push(t + 6 * (i + 1), N'((1 << (i + 1)) - 1), 1'b0);
        end
        issue(OP_EN_ALL, 8'd0);
        repeat (35) @(negedge clock);
        check("busy_before_last", 32'(busy), 32'h1);
        @(negedge clock);
        check("busy_after_all", 32'(busy), 32'h0);
        check("en_all_on", 32'(en), 32'h3f);

        t = cyc + 1;
        push(t, 6'b000000, 1'b0);
        issue(OP_DIS_ALL, 8'd0);

        // Cancel in DELAY: enable 3, disable 3 two cycles later
        issue(OP_EN, 8'd3);
        @(negedge clock);
        issue(OP_DIS, 8'd3);
        check("busy_after_cancel", 32'(busy), 32'h0);
        repeat (10) @(negedge clock);
        check("en_after_cancel", 32'(en), 32'h0);

        // Cancel queue: disable-all while channel 2 is in DELAY
        t = cyc + 1;
        push(t + 6, 6'b000001, 1'b0);
        push(t + 12, 6'b000011, 1'b0);
        issue(OP_EN_ALL, 8'd0);
        repeat (13) @(negedge clock);
        push(cyc + 1, 6'b000000, 1'b0);
        issue(OP_DIS_ALL, 8'd9);
        check("busy_after_dis_all", 32'(busy), 32'h0);
        repeat (10) @(negedge clock);
        check("en_after_dis_all", 32'(en), 32'h0);

        // Highest channel, then re-enable of an already-on channel is a no-op
        t = cyc + 1;
        push(t + 6, 6'b100000, 1'b0);
        issue(OP_EN, 8'd5);
        repeat (6) @(negedge clock);
        issue(OP_EN, 8'd5);
        check("busy_reenable", 32'(busy), 32'h0);

        // Disable accepted on the APPLY edge of the same channel wins
        issue(OP_EN, 8'd1);
        repeat (5) @(negedge clock);
        issue(OP_DIS, 8'd1);
        repeat (3) @(negedge clock);
        check("en_disable_at_apply", 32'(en), 32'h20);
        check("busy_disable_at_apply", 32'(busy), 32'h0);

        // Out-of-range indices pulse cmd_err one cycle each, en unchanged
        t = cyc + 1;
        push(t, 6'b100000, 1'b1);
        push(t + 1, 6'b100000, 1'b1);
        push(t + 2, 6'b100000, 1'b1);
        issue(OP_EN, 8'd6);
        issue(OP_EN, 8'd255);
        issue(OP_DIS, 8'd7);
        @(negedge clock);
        check("cmd_err_clears", 32'(cmd_err), 32'h0);
        check("en_after_oor", 32'(en), 32'h20);
        check("busy_after_oor", 32'(busy), 32'h0);

`ifdef MOTOR_ENABLE_WATCHDOG_EN
        // Watchdog: idle WD cycles after a command forces disable-all
        t = cyc + 1;
        push(t + int'(WD), 6'b000000, 1'b0);
        issue(OP_DIS, 8'd0);
        repeat (WD) @(negedge clock);
        check("wd_trip_set", 32'(wd_trip), 32'h1);
        issue(OP_DIS, 8'd0);
        check("wd_trip_cleared", 32'(wd_trip), 32'h0);
`else
        check("wd_trip_tied", 32'(wd_trip), 32'h0);
`endif

        repeat (4) @(negedge clock);
        check("events_drained", 32'(exp_q.size()), 32'h0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
